signed_counter_monitor: RTL and testbench

- Passive observer for the signed up/down counter output bus.
- Samples the counter value q and the up/dn command that produced it, then detects two-s-complement wrap events: overflow on an up step and underflow on a down step.
- Reports each event as a one-cycle pulse, keeps saturating event counts, and tracks the running min/max of q.
- Sits beside the counter in the datapath and feeds status and debug registers.

---
 rtl/signed_counter_monitor_pkg.sv | 16 +
 rtl/signed_counter_monitor_sat_counter.sv | 22 ++
 rtl/signed_counter_monitor.sv | 112 +++++++++++
 tb/tb_signed_counter_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/signed_counter_monitor_pkg.sv
// Shared encodings and constants for the signed counter monitor.
package signed_counter_monitor_pkg;

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b10;
  localparam logic [1:0] CMD_DN   = 2'b01;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  localparam int unsigned DEF_W = 8;
  localparam logic signed [DEF_W-1:0] SMAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic signed [DEF_W-1:0] SMIN = {1'b1, {(DEF_W-1){1'b0}}};

endpackage

// File: rtl/signed_counter_monitor_sat_counter.sv
// Saturating event counter; clr restarts the count and absorbs a same-edge increment.
module sat_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/signed_counter_monitor.sv
// Passive monitor detecting two's-complement wrap of a signed up/down counter.
module signed_counter_monitor
  import signed_counter_monitor_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic                up,
  input  logic                dn,
  input  logic signed [W-1:0] q,
  output logic                overflow,
  output logic                underflow,
  output logic [CW-1:0]       ovf_cnt,
  output logic [CW-1:0]       unf_cnt,
  output logic signed [W-1:0] q_min,
  output logic signed [W-1:0] q_max,
  output logic                sticky_err,
  output logic                armed
);

  localparam logic signed [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  logic [0:0]          state;
  logic signed [W-1:0] q_prev;
  logic [1:0]          cmd_prev;
  logic signed [W:0]   q_ext;
  logic signed [W:0]   p_ext;
  logic                ovf_det;
  logic                unf_det;

  assign q_ext = {q[W-1], q};
  assign p_ext = {q_prev[W-1], q_prev};

  // cmd_prev is the command that produced the current q, so it decides the direction.
  always_comb begin
    ovf_det = 1'b0;
    unf_det = 1'b0;
    if (en && (state == RUN)) begin
      ovf_det = (cmd_prev == CMD_UP) && (q_ext < p_ext);
      unf_det = (cmd_prev == CMD_DN) && (q_ext > p_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      q_prev    <= '0;
      cmd_prev  <= CMD_NONE;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_det;
      underflow <= unf_det;
      if (en) begin
        state    <= RUN;
        q_prev   <= q;
        cmd_prev <= {up, dn};
      end
    end
  end

  // clr restores reset values first, then the current sample is absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_min      <= QMAX;
      q_max      <= QMIN;
      sticky_err <= 1'b0;
    end else begin
      if (en) begin
        if (clr) begin
          q_min <= q;
          q_max <= q;
        end else begin
          if (q < q_min) q_min <= q;
          if (q > q_max) q_max <= q;
        end
      end else if (clr) begin
        q_min <= QMAX;
        q_max <= QMIN;
      end
      if (clr) begin
        sticky_err <= ovf_det | unf_det;
      end else if (ovf_det || unf_det) begin
        sticky_err <= 1'b1;
      end
    end
  end

  assign armed = (state == RUN);

  sat_counter #(.CW(CW)) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (ovf_det),
    .cnt (ovf_cnt)
  );

  sat_counter #(.CW(CW)) u_unf_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (unf_det),
    .cnt (unf_cnt)
  );

endmodule

// File: tb/tb_signed_counter_monitor.sv
// Directed self-checking bench for signed_counter_monitor (W=8, CW=4).
module tb_signed_counter_monitor;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en  = 1'b0;
  logic              clr = 1'b0;
  logic              up  = 1'b0;
  logic              dn  = 1'b0;
  logic signed [7:0] q   = '0;
  logic              overflow;
  logic              underflow;
  logic [3:0]        ovf_cnt;
  logic [3:0]        unf_cnt;
  logic signed [7:0] q_min;
  logic signed [7:0] q_max;
  logic              sticky_err;
  logic              armed;

  int errors = 0;
  int checks = 0;

  signed_counter_monitor #(.W(8), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .up         (up),
    .dn         (dn),
    .q          (q),
    .overflow   (overflow),
    .underflow  (underflow),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt),
    .q_min      (q_min),
    .q_max      (q_max),
    .sticky_err (sticky_err),
    .armed      (armed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ovf"},    {31'b0, overflow},   32'h0);
    check({tag, "_unf"},    {31'b0, underflow},  32'h0);
    check({tag, "_ovfcnt"}, {28'b0, ovf_cnt},    32'h0);
    check({tag, "_unfcnt"}, {28'b0, unf_cnt},    32'h0);
    check({tag, "_sticky"}, {31'b0, sticky_err}, 32'h0);
    check({tag, "_armed"},  {31'b0, armed},      32'h0);
    check({tag, "_qmin"},   {24'b0, q_min},      32'h7f);
    check({tag, "_qmax"},   {24'b0, q_max},      32'h80);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; up = 1'b0; dn = 1'b0; q = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check_reset_state("rst");

    // 1: overflow on an up step 127 -> -128
    en = 1'b1; up = 1'b1; dn = 1'b0;
    q = 8'sd125; tick();
    check("t1_armed", {31'b0, armed}, 32'h1);
    q = 8'sd126; tick();
    q = 8'sd127; tick();
    check("t1_noovf", {31'b0, overflow}, 32'h0);
    q = -8'sd128; tick();
    check("t1_ovf",    {31'b0, overflow},   32'h1);
    check("t1_ovfcnt", {28'b0, ovf_cnt},    32'h1);
    check("t1_sticky", {31'b0, sticky_err}, 32'h1);
    check("t1_qmax",   {24'b0, q_max},      32'h7f);
    check("t1_qmin",   {24'b0, q_min},      32'h80);
    en = 1'b0; tick();
    check("t1_pulse1", {31'b0, overflow}, 32'h0);
    check("t1_hold",   {28'b0, ovf_cnt},  32'h1);

    // 2: underflow on a down step -128 -> 127
    do_reset();
    en = 1'b1; up = 1'b0; dn = 1'b1;
    q = -8'sd126; tick();
    q = -8'sd127; tick();
    q = -8'sd128; tick();
    check("t2_nounf", {31'b0, underflow}, 32'h0);
    q = 8'sd127; tick();
    check("t2_unf",    {31'b0, underflow}, 32'h1);
    check("t2_unfcnt", {28'b0, unf_cnt},   32'h1);
    check("t2_ovf",    {31'b0, overflow},  32'h0);
    en = 1'b0; tick();
    check("t2_pulse1", {31'b0, underflow}, 32'h0);

    // 3: first sample never detects; up+dn step never detects
    do_reset();
    en = 1'b1; up = 1'b1; dn = 1'b0;
    q = -8'sd128; tick();
    check("t3_first", {31'b0, overflow}, 32'h0);
    check("t3_armed", {31'b0, armed},    32'h1);
    up = 1'b1; dn = 1'b1;
    q = 8'sd127; tick();
    check("t3_rise", {31'b0, overflow}, 32'h0);
    q = -8'sd128; tick();
    check("t3_both",   {31'b0, overflow},   32'h0);
    check("t3_sticky", {31'b0, sticky_err}, 32'h0);

    // 4: en=0 holds everything; later compare is against the held sample
    do_reset();
    en = 1'b1; up = 1'b0; dn = 1'b0;
    q = 8'sd127; tick();
    en = 1'b0; up = 1'b1;
    q = -8'sd128; tick();
    check("t4_gate_ovf", {31'b0, overflow}, 32'h0);
    check("t4_gate_min", {24'b0, q_min},    32'h7f);
    check("t4_gate_max", {24'b0, q_max},    32'h7f);
    check("t4_gate_arm", {31'b0, armed},    32'h1);
    en = 1'b1; tick();
    check("t4_ovf",  {31'b0, overflow}, 32'h0);
    check("t4_qmin", {24'b0, q_min},    32'h80);

    // 5: saturation at 15, then clear
    do_reset();
    en = 1'b1; up = 1'b1; dn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      q = 8'sd127;  tick();
      q = -8'sd128; tick();
      if (i == 14) check("t5_cnt15", {28'b0, ovf_cnt}, 32'hf);
    end
    check("t5_sat",    {28'b0, ovf_cnt},    32'hf);
    check("t5_sticky", {31'b0, sticky_err}, 32'h1);
    en = 1'b0; clr = 1'b1; tick();
    clr = 1'b0;
    check("t5_clr_cnt",  {28'b0, ovf_cnt},    32'h0);
    check("t5_clr_stk",  {31'b0, sticky_err}, 32'h0);
    check("t5_clr_min",  {24'b0, q_min},      32'h7f);
    check("t5_clr_max",  {24'b0, q_max},      32'h80);
    check("t5_clr_arm",  {31'b0, armed},      32'h1);
    // clr with a same-edge event: counts restart at 1, min/max take q
    en = 1'b1; q = 8'sd127; tick();
    clr = 1'b1; q = -8'sd128; tick();
    clr = 1'b0;
    check("t5_ce_ovf", {31'b0, overflow},   32'h1);
    check("t5_ce_cnt", {28'b0, ovf_cnt},    32'h1);
    check("t5_ce_stk", {31'b0, sticky_err}, 32'h1);
    check("t5_ce_min", {24'b0, q_min},      32'h80);
    check("t5_ce_max", {24'b0, q_max},      32'h80);

    // 6: reset between samples discards the held sample
    do_reset();
    en = 1'b1; up = 1'b1; dn = 1'b0;
    q = 8'sd127; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    check_reset_state("t6");
    q = -8'sd128; tick();
    check("t6_noovf", {31'b0, overflow}, 32'h0);
    check("t6_armed", {31'b0, armed},    32'h1);
    en = 1'b0; tick();
    check("t6_after", {31'b0, overflow}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
